// File: rtl/dot_prod_pkg.sv
// Shared defaults and helpers for the dot_prod streaming dot-product engine.
// The DOT_PROD_SATURATE_EN build switch is consumed by dot_prod_mac.
package dot_prod_pkg;

  localparam int unsigned DEF_DATA_W  = 8;
  localparam int unsigned DEF_OUT_W   = 16;
  localparam int unsigned DEF_VEC_LEN = 4;

  function automatic logic [DEF_OUT_W-1:0] sat_add(input logic [DEF_OUT_W-1:0] x,
                                                   input logic [DEF_OUT_W-1:0] y);
    logic [DEF_OUT_W:0] t;
    t = {1'b0, x} + {1'b0, y};
    return t[DEF_OUT_W] ? '1 : t[DEF_OUT_W-1:0];
  endfunction

endpackage

// File: rtl/dot_prod_mac.sv
// Combinational multiply-accumulate step: sum_out = acc_in + a*b.
// Wraps modulo 2^OUT_W by default; saturates when DOT_PROD_SATURATE_EN is defined.
module dot_prod_mac
  import dot_prod_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned OUT_W  = DEF_OUT_W
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [OUT_W-1:0]  acc_in,
  output logic [OUT_W-1:0]  sum_out
);

  localparam int unsigned PROD_W = 2 * DATA_W;

  logic [PROD_W-1:0] prod;
  logic [OUT_W-1:0]  p_ext;
  logic [OUT_W:0]    sum_wide;

  assign prod = a * b;

  // Fit the full-width product to the accumulator width.
  generate
    if (PROD_W >= OUT_W) begin : g_trunc
      assign p_ext = prod[OUT_W-1:0];
    end else begin : g_zext
      assign p_ext = {{(OUT_W-PROD_W){1'b0}}, prod};
    end
  endgenerate

  assign sum_wide = {1'b0, acc_in} + {1'b0, p_ext};

`ifdef DOT_PROD_SATURATE_EN
  assign sum_out = sum_wide[OUT_W] ? '1 : sum_wide[OUT_W-1:0];
`else
  assign sum_out = sum_wide[OUT_W-1:0];
`endif

endmodule

// File: rtl/dot_prod.sv
// Streaming unsigned dot-product: accumulates a*b over VEC_LEN cycles, then
// registers the sum on s with a one-cycle ready pulse. See DOT_PROD_SATURATE_EN in dot_prod_mac.
module dot_prod
  import dot_prod_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned OUT_W   = DEF_OUT_W,
  parameter int unsigned VEC_LEN = DEF_VEC_LEN
) (
  input  logic              clk,
  input  logic              reset,
  output logic [OUT_W-1:0]  s,
  output logic              ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b
);

  localparam int unsigned IDX_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_LEN - 1);

  logic [OUT_W-1:0] acc_d, acc_q;
  logic [IDX_W-1:0] idx_d, idx_q;
  logic [OUT_W-1:0] s_d, s_q;
  logic             ready_d, ready_q;
  logic [OUT_W-1:0] sum;

  dot_prod_mac #(
    .DATA_W (DATA_W),
    .OUT_W  (OUT_W)
  ) u_mac (
    .a       (a),
    .b       (b),
    .acc_in  (acc_q),
    .sum_out (sum)
  );

  always_comb begin
    acc_d   = sum;
    idx_d   = idx_q + 1'b1;
    s_d     = s_q;
    ready_d = 1'b0;
    if (idx_q == LAST_IDX) begin
      acc_d   = '0;
      idx_d   = '0;
      s_d     = sum;
      ready_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q   <= '0;
      idx_q   <= '0;
      s_q     <= '0;
      ready_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      s_q     <= s_d;
      ready_q <= ready_d;
    end
  end

  assign s     = s_q;
  assign ready = ready_q;

endmodule

// File: tb/tb_dot_prod.sv
// Directed self-checking bench for dot_prod (VEC_LEN=4 and VEC_LEN=1 instances).
// Expected values follow DOT_PROD_SATURATE_EN when it is defined for the build.
module tb_dot_prod;

  logic        clk;
  logic        reset;
  logic [7:0]  a, b;
  logic [15:0] s;
  logic        ready;

  logic        reset1;
  logic [7:0]  a1, b1;
  logic [15:0] s1;
  logic        ready1;

  int unsigned n_checks;
  int unsigned n_pass;

  dot_prod #(
    .DATA_W  (8),
    .OUT_W   (16),
    .VEC_LEN (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .s     (s),
    .ready (ready),
    .a     (a),
    .b     (b)
  );

  dot_prod #(
    .DATA_W  (8),
    .OUT_W   (16),
    .VEC_LEN (1)
  ) dut1 (
    .clk   (clk),
    .reset (reset1),
    .s     (s1),
    .ready (ready1),
    .a     (a1),
    .b     (b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [7:0] va, input logic [7:0] vb, input int unsigned n);
    a = va;
    b = vb;
    for (int i = 0; i < int'(n); i++) step();
  endtask

  initial begin
    logic [15:0] exp_ff;
    n_checks = 0;
    n_pass   = 0;
`ifdef DOT_PROD_SATURATE_EN
    exp_ff = 16'hFFFF;
`else
    exp_ff = 16'hF804;
`endif

    reset  = 1'b1;
    reset1 = 1'b1;
    a  = 8'hA3; b  = 8'h24;
    a1 = 8'h10; b1 = 8'h10;

    for (int i = 0; i < 10; i++) begin
      step();
      check("rst_s", s, 16'h0000);
      check("rst_ready", ready, 1'b0);
    end
    check("rst1_s", s1, 16'h0000);
    check("rst1_ready", ready1, 1'b0);

    // Vector of ones: result appears after the 4th edge with reset low.
    reset = 1'b0;
    a = 8'h01; b = 8'h01;
    for (int i = 0; i < 3; i++) begin
      step();
      check("ones_ready_low", ready, 1'b0);
      check("ones_s_hold", s, 16'h0000);
    end
    step();
    check("ones_s", s, 16'h0004);
    check("ones_ready", ready, 1'b1);

    a = 8'hA3; b = 8'h24;
    step();
    check("ready_one_cycle", ready, 1'b0);
    check("s_holds", s, 16'h0004);
    feed(8'hA3, 8'h24, 3);
    check("a3x24_s", s, 16'h5BB0);
    check("a3x24_ready", ready, 1'b1);

    feed(8'h02, 8'h02, 3);
    check("twos_ready_low", ready, 1'b0);
    check("twos_s_hold", s, 16'h5BB0);
    step();
    check("twos_s", s, 16'h0010);
    check("twos_ready", ready, 1'b1);

    feed(8'hFF, 8'hFF, 4);
    check("ff_s", s, exp_ff);
    check("ff_ready", ready, 1'b1);

    // Abort a vector after two elements; the partial sum must not leak.
    feed(8'h05, 8'h05, 2);
    check("partial_ready", ready, 1'b0);
    reset = 1'b1;
    step();
    check("midrst_s", s, 16'h0000);
    check("midrst_ready", ready, 1'b0);
    reset = 1'b0;
    feed(8'h03, 8'h03, 3);
    check("threes_ready_low", ready, 1'b0);
    step();
    check("threes_s", s, 16'h0024);
    check("threes_ready", ready, 1'b1);

    reset1 = 1'b0;
    step();
    check("len1_s", s1, 16'h0100);
    check("len1_ready", ready1, 1'b1);
    a1 = 8'h20; b1 = 8'h03;
    step();
    check("len1_s_track", s1, 16'h0060);
    check("len1_ready_hi", ready1, 1'b1);
    a1 = 8'hFF; b1 = 8'hFF;
    step();
    check("len1_s_ff", s1, 16'hFE01);
    check("len1_ready_hi2", ready1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
